// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline types and constants for the RV32 core.
// Holds the hazard FSM state enum and register-address defaults.
package rv32_pipe_pkg;

    localparam int REG_AW = 5;
    localparam int X0     = 0;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping stall / flush event counters for the hazard controller.
// Used only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / dmem-wait hazard controller for the ID bubble mux.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int REG_AW = rv32_pipe_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              muxsel,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    hz_state_t state;
    hz_state_t state_nx;
    logic      pend_flush;
    logic      pend_nx;
    logic      lu;
    logic      lu_stall;
    logic      frozen;
    logic      flush;

    assign lu = ex_memread
             && (ex_rd != REG_AW'(X0))
             && ((id_use_rs1 && (id_rs1 == ex_rd))
              || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        frozen = 1'b0;
        unique case (state)
            RUN:     frozen = dmem_req && !dmem_ready;
            WAIT:    frozen = !dmem_ready;
            default: frozen = 1'b0;
        endcase
    end

    assign flush    = !frozen && (ex_branch_taken || pend_flush);
    assign lu_stall = !frozen && !flush && lu;

    // Staying frozen is exactly the condition for being in WAIT next cycle.
    assign state_nx = frozen ? WAIT : RUN;
    assign pend_nx  = frozen && (pend_flush || ex_branch_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nx;
            pend_flush <= pend_nx;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        muxsel       = 1'b0;
        if_id_flush  = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            muxsel       = 1'b1;
            if_id_flush  = 1'b1;
        end else begin
            unique case (1'b1)
                frozen: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                end
                flush: begin
                    muxsel      = 1'b1;
                    if_id_flush = 1'b1;
                end
                lu_stall: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    muxsel      = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_inc   (frozen || lu_stall),
        .flush_inc   (flush),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan steps plus a random phase.
module tb_hazard_ctrl;
    import rv32_pipe_pkg::*;

    // Output vector: {pc, if_id, id_ex, ex_mem, mem_wb, muxsel, if_id_flush}
    localparam logic [6:0] V_RUN = 7'b11111_00;
    localparam logic [6:0] V_LU  = 7'b00111_10;
    localparam logic [6:0] V_FL  = 7'b11111_11;
    localparam logic [6:0] V_FRZ = 7'b00000_00;
    localparam logic [6:0] V_RST = 7'b00000_11;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_memread, ex_branch_taken;
    logic       dmem_req, dmem_ready;
    logic       muxsel, pc_write, if_id_write;
    logic       id_ex_write, ex_mem_write, mem_wb_write;
    logic       if_id_flush;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;
    int n_stall = 0;
    int n_flush = 0;
    logic [6:0] exp_q[$];
    logic       m_w, m_p;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_memread     (ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .muxsel         (muxsel),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_write   (mem_wb_write),
        .if_id_flush    (if_id_flush)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs already driven; push expectation, compare mid-cycle, cross edge.
    task automatic cyc(input string tag, input logic [6:0] e);
        logic [6:0] want;
        exp_q.push_back(e);
        if (rst) begin
            n_stall = 0;
            n_flush = 0;
        end else begin
            if (e == V_FRZ || e == V_LU) n_stall++;
            if (e == V_FL) n_flush++;
        end
        @(negedge clk);
        want = exp_q.pop_front();
        check(tag, {25'd0, pc_write, if_id_write, id_ex_write,
                    ex_mem_write, mem_wb_write, muxsel, if_id_flush},
              {25'd0, want});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] model(input logic r, input logic l,
                                         input logic b, input logic q,
                                         input logic y);
        logic fz;
        fz = m_w ? !y : (q && !y);
        if (r)             return V_RST;
        else if (fz)       return V_FRZ;
        else if (b || m_p) return V_FL;
        else if (l)        return V_LU;
        return V_RUN;
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_out", V_RST);
        check("reset_state", 32'(dut.state), 32'(RUN));
        check("reset_pend", 32'(dut.pend_flush), 32'd0);
        idle();

        // load-use on rs2
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cyc("lu_stall", V_LU);
        ex_memread = 1'b0;
        cyc("lu_after", V_RUN);

        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("lu_x0", V_RUN);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1; id_use_rs2 = 1'b0;
        cyc("lu_rs1_unused", V_RUN);
        id_use_rs1 = 1'b1;
        cyc("lu_rs1", V_LU);

        ex_branch_taken = 1'b1;
        cyc("flush_over_lu", V_FL);
        idle();

        // plain dmem freeze
        dmem_req = 1'b1;
        cyc("frz1", V_FRZ);
        check("st_wait", 32'(dut.state), 32'(WAIT));
        cyc("frz2", V_FRZ);
        cyc("frz3", V_FRZ);
        dmem_ready = 1'b1;
        cyc("frz_done", V_RUN);
        check("st_run", 32'(dut.state), 32'(RUN));
        idle();

        // branch pulse during WAIT cycle 2
        dmem_req = 1'b1;
        cyc("bw1", V_FRZ);
        ex_branch_taken = 1'b1;
        cyc("bw2", V_FRZ);
        ex_branch_taken = 1'b0;
        check("pend_set", 32'(dut.pend_flush), 32'd1);
        cyc("bw3", V_FRZ);
        dmem_ready = 1'b1;
        cyc("bw_replay", V_FL);
        check("pend_clr", 32'(dut.pend_flush), 32'd0);
        idle();
        cyc("bw_after", V_RUN);

        // ready and branch together in WAIT
        dmem_req = 1'b1;
        cyc("sim_wait", V_FRZ);
        dmem_ready = 1'b1; ex_branch_taken = 1'b1;
        cyc("sim_flush", V_FL);
        check("sim_pend", 32'(dut.pend_flush), 32'd0);
        idle();
        cyc("sim_after", V_RUN);

        dmem_ready = 1'b1;
        cyc("rdy_no_req", V_RUN);
        check("rdy_st", 32'(dut.state), 32'(RUN));
        idle();

        // reset mid-WAIT with a pending flush
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        cyc("rw_frz", V_FRZ);
`ifdef HAZARD_PERF_EN
        check("perf_stall", stall_cycles, 32'(n_stall));
        check("perf_flush", flush_count, 32'(n_flush));
`endif
        rst = 1'b1;
        cyc("rw_rst", V_RST);
        idle();
        check("rw_state", 32'(dut.state), 32'(RUN));
        check("rw_pend", 32'(dut.pend_flush), 32'd0);
`ifdef HAZARD_PERF_EN
        check("perf_rst", stall_cycles, 32'd0);
`endif
        cyc("rw_after", V_RUN);

        // random phase against the bench model
        m_w = 1'b0;
        m_p = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic l, fz;
            logic [6:0] e;
            rst = ($urandom_range(0, 29) == 0);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_memread = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            dmem_req = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 2) == 0);
            l = ex_memread && ex_rd != 5'd0
                && ((id_use_rs1 && id_rs1 == ex_rd)
                 || (id_use_rs2 && id_rs2 == ex_rd));
            e = model(rst, l, ex_branch_taken, dmem_req, dmem_ready);
            fz = (e == V_FRZ);
            cyc("rand", e);
            if (rst) begin
                m_w = 1'b0;
                m_p = 1'b0;
            end else begin
                m_p = fz && (m_p || ex_branch_taken);
                m_w = fz;
            end
        end
`ifdef HAZARD_PERF_EN
        check("perf_rand_stall", stall_cycles, 32'(n_stall));
        check("perf_rand_flush", flush_count, 32'(n_flush));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
